exec_unit: RTL

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/exec_unit_pkg.sv | 20 ++
 rtl/exec_unit_alu.sv | 31 +++
 rtl/exec_unit.sv | 104 ++++++++++
 3 files changed

// File: rtl/exec_unit_pkg.sv
// Shared definitions for the exec_unit slice: ALU opcode constants and the
// control FSM state encoding.
package exec_unit_pkg;

    localparam logic [2:0] OC_ADD = 3'b000;
    localparam logic [2:0] OC_SUB = 3'b001;
    localparam logic [2:0] OC_MUL = 3'b010;
    localparam logic [2:0] OC_DIV = 3'b011;
    localparam logic [2:0] OC_NOT = 3'b100;
    localparam logic [2:0] OC_XOR = 3'b101;
    localparam logic [2:0] OC_OR  = 3'b110;
    localparam logic [2:0] OC_AND = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/exec_unit_alu.sv
// Combinational ALU used by exec_unit. All arithmetic wraps modulo
// 2^DATA_WIDTH; a zero divisor yields all ones so the divider output is
// always defined.
module alu
    import exec_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [2:0]            oc,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] f
);

    // Select one operation result by opcode; NOT only looks at operand A.
    always_comb begin
        f = '0;
        case (oc)
            OC_ADD:  f = a + b;
            OC_SUB:  f = a - b;
            OC_MUL:  f = a * b;
            OC_DIV:  f = (b == '0) ? '1 : a / b;
            OC_NOT:  f = ~a;
            OC_XOR:  f = a ^ b;
            OC_OR:   f = a | b;
            OC_AND:  f = a & b;
            default: f = '0;
        endcase
    end

endmodule

// File: rtl/exec_unit.sv
// exec_unit: single-command execution unit around the combinational alu.
// A three-state FSM (IDLE -> EXEC -> DONE) accepts a command, registers the
// ALU result with zero/error flags, and holds it until the consumer takes it.
// The accumulator captures each consumed result and can replace operand A.
// Build option: define EXEC_UNIT_DIV_EN to enable division; without it every
// div reports an error with a zero result and the quotient is never used.
module exec_unit
    import exec_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_oc,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_use_acc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_f,
    output logic                  out_zero,
    output logic                  out_err
);

    state_t                state;
    logic [2:0]            oc_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] alu_f;
    logic [DATA_WIDTH-1:0] res_f;
    logic                  res_err;

    // Handshake flags follow the state register and are forced low during reset.
    assign in_ready  = (state == ST_IDLE) && !rst;
    assign out_valid = (state == ST_DONE) && !rst;

    alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .oc (oc_q),
        .a  (a_q),
        .b  (b_q),
        .f  (alu_f)
    );

    // Apply the divide policy on top of the raw ALU output.
    always_comb begin
        res_f   = alu_f;
        res_err = 1'b0;
        if (oc_q == OC_DIV) begin
`ifdef EXEC_UNIT_DIV_EN
            if (b_q == '0) begin
                res_f   = '1;
                res_err = 1'b1;
            end
`else
            res_f   = '0;
            res_err = 1'b1;
`endif
        end
    end

    // Control FSM with operand capture, result registers and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            oc_q     <= OC_ADD;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            out_f    <= '0;
            out_zero <= 1'b0;
            out_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        oc_q  <= in_oc;
                        a_q   <= in_use_acc ? acc : in_a;
                        b_q   <= in_b;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    out_f    <= res_f;
                    out_zero <= (res_f == '0);
                    out_err  <= res_err;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        acc   <= out_f;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
